// File: rtl/exp_align_stage.sv
// exp_align_stage
//   Alignment stage that sits after the max-exponent tree in the MAC datapath.
//   Each of the LANES product significands is right-shifted by
//   (max_exp - exp_k), with guard/round/sticky bits appended. The result is
//   then converted to two's complement for the adder tree. The stage is a
//   two-deep valid/ready pipeline.
//
// Ports
//   i_clk, i_rst      clock; asynchronous active-high reset
//   i_valid / o_ready upstream handshake
//   i_max_exp         maximum product exponent from the tree
//   i_exp             packed product exponents, lane k at [6k+5:6k]
//   i_sign            product signs, one bit per lane
//   i_sig             packed unsigned product significands
//   o_valid / i_ready downstream handshake
//   o_aligned         packed two's-complement aligned lanes (ALIGN_WIDTH+1 each)
//   o_max_exp         exponent that travels with o_aligned
//   o_err             some lane had exp > max_exp in this transaction
//   o_number          static gate count of comparator, mux and shifter cells
module exp_align_stage #(
    parameter int FP16_exp_width = 5,
    parameter int SIG_WIDTH      = 22,
    parameter int LANES          = 9,
    parameter int ALIGN_WIDTH    = SIG_WIDTH + 3
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [FP16_exp_width:0]                i_max_exp,
    input  logic [LANES*(FP16_exp_width+1)-1:0]    i_exp,
    input  logic [LANES-1:0]                       i_sign,
    input  logic [LANES*SIG_WIDTH-1:0]             i_sig,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic [LANES*(ALIGN_WIDTH+1)-1:0]       o_aligned,
    output logic [FP16_exp_width:0]                o_max_exp,
    output logic                                   o_err,
    output logic [50:0]                            o_number
);

    localparam int EW  = FP16_exp_width + 1;   // exponent width
    localparam int DW  = EW + 1;               // signed difference width
    localparam int AW1 = ALIGN_WIDTH + 1;      // signed aligned lane width

    // Static cell inventory, per lane:
    //   comparators: DW-bit subtractor, range compare on diff, exponent zero detect
    //   shifter:     five mux levels across the magnitude plus the sticky OR chain
    //   muxes:       force-to-zero select and sign (negate) select
    localparam int unsigned CMP_PER_LANE = DW * 5 + DW + EW + 1;
    localparam int unsigned SHF_PER_LANE = ALIGN_WIDTH * 5 + ALIGN_WIDTH;
    localparam int unsigned MUX_PER_LANE = AW1 * 2;
    localparam int unsigned GATE_TOTAL   = LANES * (CMP_PER_LANE + SHF_PER_LANE + MUX_PER_LANE);

    assign o_number = 51'(GATE_TOTAL);

    // Stage 1 registers
    logic                          s1_valid_q;
    logic [EW-1:0]                 s1_max_q;
    logic [LANES*EW-1:0]           s1_exp_q;
    logic [LANES-1:0]              s1_sign_q;
    logic [LANES*SIG_WIDTH-1:0]    s1_sig_q;

    // Stage 2 registers
    logic                          s2_valid_q, s2_valid_d;
    logic [LANES*AW1-1:0]          s2_aligned_q, s2_aligned_d;
    logic [EW-1:0]                 s2_max_q;
    logic                          s2_err_q, s2_err_d;

    logic s1_valid_d;
    logic s1_load, s2_load;

    // Shift one lane right by (max_exp - exp); the bits that fall off the
    // bottom collapse into bit 0. The lane is then sign-converted.
    function automatic logic [AW1-1:0] align_lane(
        input logic [EW-1:0]        max_exp,
        input logic [EW-1:0]        exp_v,
        input logic                 sign,
        input logic [SIG_WIDTH-1:0] sig
    );
        logic [DW-1:0]          diff;
        logic [ALIGN_WIDTH-1:0] m;
        logic [ALIGN_WIDTH-1:0] mag;
        logic                   sticky;
        logic [AW1-1:0]         ext;
        diff   = {1'b0, max_exp} - {1'b0, exp_v};
        m      = {sig, 3'b000};
        sticky = 1'b0;
        for (int unsigned i = 0; i < ALIGN_WIDTH; i++) begin
            if (i < 32'(diff)) sticky = sticky | m[i];
        end
        if (32'(diff) >= ALIGN_WIDTH) begin
            mag    = '0;
            mag[0] = |sig;
        end else begin
            mag    = m >> diff;
            mag[0] = mag[0] | sticky;
        end
        // Zero products and negative differences contribute nothing.
        if (exp_v == '0 || diff[DW-1]) mag = '0;
        ext = {1'b0, mag};
        if (sign) ext = '0 - ext;
        return ext;
    endfunction

    assign o_ready = !s1_valid_q || !s2_valid_q || i_ready;
    assign s1_load = i_valid && o_ready;
    assign s2_load = s1_valid_q && (!s2_valid_q || i_ready);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s2_valid_d   = s2_valid_q;
        s2_aligned_d = '0;
        s2_err_d     = 1'b0;
        if (s1_load)      s1_valid_d = 1'b1;
        else if (s2_load) s1_valid_d = 1'b0;
        if (s2_load)      s2_valid_d = 1'b1;
        else if (i_ready) s2_valid_d = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            s2_aligned_d[k*AW1 +: AW1] = align_lane(s1_max_q, s1_exp_q[k*EW +: EW],
                                                    s1_sign_q[k], s1_sig_q[k*SIG_WIDTH +: SIG_WIDTH]);
            if (s1_exp_q[k*EW +: EW] > s1_max_q) s2_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q   <= 1'b0;
            s1_max_q     <= '0;
            s1_exp_q     <= '0;
            s1_sign_q    <= '0;
            s1_sig_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_aligned_q <= '0;
            s2_max_q     <= '0;
            s2_err_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                s1_max_q  <= i_max_exp;
                s1_exp_q  <= i_exp;
                s1_sign_q <= i_sign;
                s1_sig_q  <= i_sig;
            end
            if (s2_load) begin
                s2_aligned_q <= s2_aligned_d;
                s2_max_q     <= s1_max_q;
                s2_err_q     <= s2_err_d;
            end
        end
    end

    assign o_valid   = s2_valid_q;
    assign o_aligned = s2_aligned_q;
    assign o_max_exp = s2_max_q;
    assign o_err     = s2_err_q;

endmodule

// File: tb/tb_exp_align_stage.sv
// Testbench for exp_align_stage: directed vectors, an arithmetic reference
// model and a scoreboard queue. The queue is checked on every cycle that
// o_valid is high.
module tb_exp_align_stage;

    localparam int EW = 6;
    localparam int SW = 22;
    localparam int L  = 9;
    localparam int AW = 26;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_ready = 1'b1;
    logic [EW-1:0]     i_max_exp = '0;
    logic [L*EW-1:0]   i_exp = '0;
    logic [L-1:0]      i_sign = '0;
    logic [L*SW-1:0]   i_sig = '0;
    logic              o_ready, o_valid, o_err;
    logic [L*AW-1:0]   o_aligned;
    logic [EW-1:0]     o_max_exp;
    logic [50:0]       o_number;

    exp_align_stage #(.FP16_exp_width(5), .SIG_WIDTH(22), .LANES(9), .ALIGN_WIDTH(25)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_max_exp(i_max_exp), .i_exp(i_exp), .i_sign(i_sign), .i_sig(i_sig),
        .o_valid(o_valid), .i_ready(i_ready), .o_aligned(o_aligned),
        .o_max_exp(o_max_exp), .o_err(o_err), .o_number(o_number)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [EW-1:0]   mx;
        logic [L*EW-1:0] ex;
        logic [L-1:0]    sg;
        logic [L*SW-1:0] sig;
    } vec_t;

    typedef struct {
        logic [L*AW-1:0] al;
        logic [EW-1:0]   mx;
        logic            err;
        int              acc;
    } exp_t;

    exp_t        q[$];
    int          ncheck = 0;
    int          nfail = 0;
    int          ndone = 0;
    int          cyc = 0;
    bit          check_lat = 1'b0;
    bit          saw_nready = 1'b0;
    bit          num_seen = 1'b0;
    bit          num_changed = 1'b0;
    logic [50:0] num_prev = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        ncheck++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference arithmetic: value = sig*8 / 2^diff, with any nonzero remainder
    // setting the lowest bit; then take the two's complement modulo 2^26.
    function automatic logic [AW-1:0] lane_model(int mx, int ex, bit s, longint sig);
        longint m, mag;
        int     diff;
        diff = mx - ex;
        if (ex == 0 || diff < 0) return '0;
        m = sig * 8;
        if (diff >= 25) mag = (sig != 0) ? 1 : 0;
        else mag = (m >> diff) | (((m % (longint'(1) << diff)) != 0) ? 1 : 0);
        if (s) mag = ((longint'(1) << 26) - mag) % (longint'(1) << 26);
        return mag[AW-1:0];
    endfunction

    function automatic exp_t model(vec_t v, int acc);
        exp_t e;
        e.al  = '0;
        e.err = 1'b0;
        e.mx  = v.mx;
        e.acc = acc;
        for (int k = 0; k < L; k++) begin
            e.al[k*AW +: AW] = lane_model(int'(v.mx), int'(v.ex[k*EW +: EW]), v.sg[k],
                                          longint'(v.sig[k*SW +: SW]));
            if (v.ex[k*EW +: EW] > v.mx) e.err = 1'b1;
        end
        return e;
    endfunction

    function automatic vec_t zero_vec();
        vec_t v;
        v.mx  = '0;
        v.ex  = '0;
        v.sg  = '0;
        v.sig = '0;
        return v;
    endfunction

    function automatic vec_t gen(int i);
        vec_t v;
        int   mx, ex;
        v  = zero_vec();
        mx = 20 + (i % 10);
        v.mx = 6'(mx);
        for (int k = 0; k < L; k++) begin
            ex = mx - ((i * 7 + k * 3) % 30);
            if (k == i % 9 && i % 4 == 0) ex = mx + 1;
            v.ex[k*EW +: EW]  = 6'(ex);
            v.sg[k]           = 1'((i + k) % 2);
            v.sig[k*SW +: SW] = 22'(i * 32'h1357 + k * 32'h2468B + 1);
        end
        return v;
    endfunction

    function automatic vec_t cur_vec();
        vec_t v;
        v.mx  = i_max_exp;
        v.ex  = i_exp;
        v.sg  = i_sign;
        v.sig = i_sig;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the vector was accepted.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_max_exp = v.mx;
        i_exp = v.ex;
        i_sign = v.sg;
        i_sig = v.sig;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 256'(o_ready), 256'(1));
                break;
            end
            @(posedge i_clk);
            #1;
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || o_valid) && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("drain", 256'(q.size() != 0 || o_valid), 256'(0));
    endtask

    always @(posedge i_clk) cyc++;

    // Scoreboard compare: outputs are sampled on the falling edge, between active edges.
    always @(negedge i_clk) begin
        if (i_rst) begin
            q.delete();
        end else begin
            chk("o_number_nonzero", 256'(o_number != 0), 256'(1));
            if (num_seen && o_number != num_prev) num_changed = 1'b1;
            num_prev = o_number;
            num_seen = 1'b1;
            if (!o_ready) saw_nready = 1'b1;
            if (o_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 256'(o_valid), 256'(0));
                end else begin
                    chk("o_aligned", 256'(o_aligned), 256'(q[0].al));
                    chk("o_max_exp", 256'(o_max_exp), 256'(q[0].mx));
                    chk("o_err", 256'(o_err), 256'(q[0].err));
                    if (i_ready) begin
                        if (check_lat) chk("latency", 256'(cyc - q[0].acc), 256'(2));
                        void'(q.pop_front());
                        ndone++;
                    end
                end
            end
            if (i_valid && o_ready) q.push_back(model(cur_vec(), cyc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   base;

        // Hand-computed pins on the reference model
        chk("pin_basic0", 256'(lane_model(20, 20, 0, 64'h200000)), 256'(26'h1000000));
        chk("pin_basic1", 256'(lane_model(20, 18, 1, 64'h200000)), 256'(26'h3C00000));
        chk("pin_sticky", 256'(lane_model(40, 38, 0, 64'h3)), 256'(26'h6));
        chk("pin_sat", 256'(lane_model(40, 10, 0, 64'h1)), 256'(26'h1));
        chk("pin_shift2", 256'(lane_model(10, 8, 0, 64'h5)), 256'(26'hA));
        chk("pin_stk4", 256'(lane_model(10, 6, 0, 64'h5)), 256'(26'h3));
        chk("pin_neg", 256'(lane_model(12, 13, 0, 64'h3FFFFF)), 256'(26'h0));
        chk("pin_zero", 256'(lane_model(5, 0, 1, 64'h7)), 256'(26'h0));

        // Reset state
        #1;
        chk("rst_o_valid", 256'(o_valid), 256'(0));
        chk("rst_o_ready", 256'(o_ready), 256'(1));
        chk("rst_o_aligned", 256'(o_aligned), 256'(0));
        chk("rst_o_max_exp", 256'(o_max_exp), 256'(0));
        chk("rst_o_err", 256'(o_err), 256'(0));
        #12 i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Directed: basic align, sticky/saturation, error
        check_lat = 1'b1;
        base = ndone;
        v = zero_vec();
        v.mx = 6'd20;
        v.ex[0*EW +: EW] = 6'd20; v.sig[0*SW +: SW] = 22'h200000;
        v.ex[1*EW +: EW] = 6'd18; v.sig[1*SW +: SW] = 22'h200000; v.sg[1] = 1'b1;
        for (int k = 2; k < L; k++) begin
            v.sig[k*SW +: SW] = 22'h3FFFFF;
            v.sg[k] = 1'b1;
        end
        send(v);
        v = zero_vec();
        v.mx = 6'd40;
        v.ex[0*EW +: EW] = 6'd38; v.sig[0*SW +: SW] = 22'h000003;
        v.ex[1*EW +: EW] = 6'd10; v.sig[1*SW +: SW] = 22'h000001;
        send(v);
        v = zero_vec();
        v.mx = 6'd12;
        for (int k = 0; k < L; k++) begin
            v.ex[k*EW +: EW]  = 6'(12 - k);
            v.sig[k*SW +: SW] = 22'h200000 | 22'(k);
            v.sg[k]           = 1'(k % 2);
        end
        v.ex[4*EW +: EW] = 6'd13;
        send(v);
        wait_drain();
        chk("count_directed", 256'(ndone - base), 256'(3));

        // Back-pressure: 5 transactions, downstream stalls for 3 cycles
        check_lat = 1'b0;
        saw_nready = 1'b0;
        base = ndone;
        fork
            begin
                for (int i = 0; i < 5; i++) send(gen(100 + i));
            end
            begin
                repeat (2) @(posedge i_clk);
                #1 i_ready = 1'b0;
                repeat (3) @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_o_ready_dropped", 256'(saw_nready), 256'(1));
        chk("count_bp", 256'(ndone - base), 256'(5));

        // Full-rate flow
        check_lat = 1'b1;
        base = ndone;
        for (int i = 0; i < 20; i++) send(gen(i));
        wait_drain();
        chk("count_full_rate", 256'(ndone - base), 256'(20));

        // Reset mid-stream with a result on the output
        send(gen(200));
        send(gen(201));
        #2;
        chk("pre_reset_valid", 256'(o_valid), 256'(1));
        i_rst = 1'b1;
        #1;
        chk("mid_rst_o_valid", 256'(o_valid), 256'(0));
        chk("mid_rst_o_ready", 256'(o_ready), 256'(1));
        chk("mid_rst_o_aligned", 256'(o_aligned), 256'(0));
        chk("mid_rst_o_max_exp", 256'(o_max_exp), 256'(0));
        chk("mid_rst_o_err", 256'(o_err), 256'(0));
        @(posedge i_clk);
        #3 i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        base = ndone;
        send(gen(202));
        wait_drain();
        chk("count_after_reset", 256'(ndone - base), 256'(1));

        chk("o_number_constant", 256'(num_changed), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule

// File: doc/exp_align_stage.md
Name: exp_align_stage

Overview:
- Alignment stage directly downstream of the max-exponent tree in the MAC datapath.
- Takes the tree's final maximum product exponent, plus the exponent, sign and significand of each of the 9 FP16 products.
- Right-shifts every significand by (max_exp − exp_i) with guard/round/sticky, then converts it to two's complement for the adder tree.
- Two-stage valid/ready pipeline; also reports its static gate count on o_number, in the same style as the other MAC_subsystem stages.

Parameters:
- FP16_exp_width, 5: product exponent bus is FP16_exp_width+1 = 6 bits.
- SIG_WIDTH, 22: unsigned product significand width (11b × 11b).
- LANES, 9: number of products aligned per transaction.
- ALIGN_WIDTH, SIG_WIDTH+3: shifted magnitude width (significand, guard, round, sticky).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  upstream transaction valid.
- o_ready  out  1  stage can accept a transaction.
- i_max_exp  in  FP16_exp_width+1  max exponent from the max-exponent tree.
- i_exp  in  LANES*(FP16_exp_width+1)  packed product exponents; lane k at [6k+5:6k].
- i_sign  in  LANES  product signs.
- i_sig  in  LANES*SIG_WIDTH  packed unsigned significands.
- o_valid  out  1  aligned result valid.
- i_ready  in  1  downstream accepts.
- o_aligned  out  LANES*(ALIGN_WIDTH+1)  packed two's-complement aligned values.
- o_max_exp  out  FP16_exp_width+1  exponent accompanying o_aligned.
- o_err  out  1  some lane had exp > max_exp in this transaction.
- o_number  out  51  static gate count, summed over all instantiated cells.

Behaviour:
- Reset (async, i_rst=1):
  - Both stage valids clear, so o_valid=0 and o_ready=1.
  - o_aligned=0, o_max_exp=0, o_err=0.
  - Reset mid-transaction discards all in-flight data; no partial output is ever presented.
- Stage 1 (S1):
  - Capture on i_valid & o_ready: registers i_max_exp, i_exp, i_sign, i_sig.
  - Computes per lane diff_k = max_exp − exp_k in 7 bits; bit 6 set marks a negative diff (error).
- Stage 2 (S2):
  - Loads from S1 when S1 is valid and (!S2_valid | i_ready).
  - Latency: 2 cycles from input acceptance to o_valid with no stall.
  - Throughput: 1 transaction per cycle.
- Handshake:
  - o_ready = !S1_valid | (!S2_valid | i_ready).
  - Output transfers on o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_aligned, o_max_exp and o_err hold stable.
  - Simultaneous output transfer and input capture in the same cycle is legal and loses no data.
- Per-lane alignment:
  - Magnitude m = {sig_k, 3'b000}, shifted right by diff_k.
  - Every bit shifted out of position 0 ORs into the sticky bit (bit 0).
  - If diff_k ≥ ALIGN_WIDTH: magnitude = 0, with sticky = |sig_k.
  - If exp_k == 0 (zero product): lane forced to 0, regardless of sig or sign.
  - If diff_k is negative: lane forced to 0 and the transaction's o_err is set.
- Sign conversion:
  - The aligned magnitude is zero-extended to ALIGN_WIDTH+1 bits.
  - If sign_k=1, the lane is negated in two's complement.
- o_max_exp is the S1-registered max_exp, passed through unchanged with its transaction.
- o_number:
  - Combinational constant: sum of the number outputs of all comparator, mux and shifter cells.
  - Independent of clock, reset and data.

Test Plan:
- Reset:
  - Stimulus: assert i_rst mid-stream with o_valid=1.
  - Required: o_valid=0, o_ready=1 and o_aligned=0 immediately, without waiting for a clock edge.
  - After release: the next accepted transaction appears exactly 2 cycles later.
- Basic align:
  - Stimulus: max_exp=20; lane0 exp=20, sig=22'h200000, sign 0; lane1 exp=18, same sig, sign 1; other lanes exp=0.
  - Required: lane0 = 26'h1000000; lane1 = −(26'h400000) = 26'h3C00000; other lanes = 0; o_err=0.
- Sticky and saturation:
  - Stimulus: max_exp=40; lane0 exp=38, sig=22'h000003; lane1 exp=10, sig=22'h000001.
  - Required: lane0 = 26'h6, with the shifted-out bit absorbed into sticky; lane1 = 26'h1 (diff 30 ≥ 25, sticky only).
- Error:
  - Stimulus: max_exp=12 with lane4 exp=13.
  - Required: o_err=1; lane4 = 0; other lanes aligned normally.
- Back-pressure:
  - Stimulus: stream 5 transactions at 1/cycle; hold i_ready=0 for 3 cycles mid-stream.
  - Required: o_ready drops once both stages are full; outputs stay stable while stalled; all 5 transactions emerge in order, none dropped or duplicated.
- Full-rate flow:
  - Stimulus: i_valid=1 and i_ready=1 continuously for 20 cycles.
  - Required: o_valid is continuous from cycle 2 onward; each output matches the input from 2 cycles earlier.
  - o_number is nonzero and constant throughout.
